// File: rtl/pb_code_loader.sv
// ---------------------------------------------------------------------------
// pb_code_loader
//
// Writer side of the PicoBlaze (KCPSM3) program-RAM load port. A framed byte
// stream arrives over a valid/ready handshake. Each group of three bytes is
// packed into one 18-bit instruction and written to program RAM, starting at
// address 0. The processor is held in reset while a frame is being loaded.
//
// Frame: SYNC, CNT_HI, CNT_LO, N x {B2, B1, B0} [, CHK]
//   N           = {CNT_HI[1:0], CNT_LO} + 1   (1..1024)
//   instruction = {B2[1:0], B1, B0}
//
// Configuration macro:
//   PB_LOADER_CHECKSUM_EN - when defined, a CHK byte follows the last word. It
//                           must equal the 8-bit sum of CNT_HI, CNT_LO and every
//                           instruction byte. When undefined, no CHK byte is
//                           expected and no checksum logic is built.
//
// Ports:
//   clk_i               system clock (also drives the program-RAM LOAD_CLK)
//   reset_i             synchronous, active-high reset
//   in_data_i[7:0]      stream byte
//   in_valid_i          in_data_i is valid
//   in_ready_o          byte is accepted when in_valid_i && in_ready_o
//   load_address_o[9:0] program-RAM write address
//   load_instruction_o  program-RAM write data (18 bits)
//   load_we_o           program-RAM write enable, one-cycle pulse per word
//   pb_reset_o          holds the KCPSM3 in reset
//   busy_o              frame in progress
//   done_o              one-cycle pulse: frame loaded successfully
//   error_o             one-cycle pulse: frame aborted (timeout or checksum)
// ---------------------------------------------------------------------------
module pb_code_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [9:0]  load_address_o,
    output logic [17:0] load_instruction_o,
    output logic        load_we_o,
    output logic        pb_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_B2,
        S_B1,
        S_B0,
        S_WRITE,
        S_CHK,
        S_FIN
    } state_e;

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [9:0]    addr_q, addr_d;
    logic [17:0]   instr_q, instr_d;
    logic          we_q, we_d;
    logic          pbrst_q, pbrst_d;
    logic          err_q, err_d;
    logic [9:0]    remain_q, remain_d;
    logic [1:0]    b2_q, b2_d;
    logic [7:0]    b1_q, b1_d;
    logic [TW-1:0] tmo_q, tmo_d;
`ifdef PB_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic accept;
    logic byte_state;

    // Next-state and output logic. in_ready is registered, so it is computed
    // from the next state: it is low only while the next state is WRITE or FIN
    // (and during reset).
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        we_d     = 1'b0;
        pbrst_d  = pbrst_q;
        err_d    = 1'b0;
        remain_d = remain_q;
        b2_d     = b2_q;
        b1_d     = b1_q;
        tmo_d    = '0;
`ifdef PB_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        accept     = in_valid_i && ready_q;
        byte_state = (state_q != S_IDLE) && (state_q != S_WRITE) && (state_q != S_FIN);

        case (state_q)
            S_IDLE: begin
                if (accept && (in_data_i == SYNC_BYTE)) begin
                    state_d = S_CNT_HI;
                    pbrst_d = 1'b1;
                    addr_d  = 10'd0;
`ifdef PB_LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    remain_d[9:8] = in_data_i[1:0];
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    remain_d[7:0] = in_data_i;
                    state_d       = S_B2;
                end
            end
            S_B2: begin
                if (accept) begin
                    b2_d    = in_data_i[1:0];
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (accept) begin
                    b1_d    = in_data_i;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (accept) begin
                    instr_d = {b2_q, b1_q, in_data_i};
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            // remain counts the words still to come after the one being written
            S_WRITE: begin
                addr_d = addr_q + 10'd1;
                if (remain_q == 10'd0) begin
`ifdef PB_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    remain_d = remain_q - 10'd1;
                    state_d  = S_B2;
                end
            end
`ifdef PB_LOADER_CHECKSUM_EN
            // A bad checksum leaves the processor in reset: RAM is partly overwritten
            S_CHK: begin
                if (accept) begin
                    if (in_data_i == sum_q) begin
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_FIN: begin
                pbrst_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PB_LOADER_CHECKSUM_EN
        if (accept && (state_q inside {S_CNT_HI, S_CNT_LO, S_B2, S_B1, S_B0})) begin
            sum_d = sum_q + in_data_i;
        end
`endif

        // Inter-byte watchdog; pb_reset is deliberately left asserted on abort
        if (byte_state && !accept) begin
            if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        ready_d = (state_d != S_WRITE) && (state_d != S_FIN);
    end

    // State and output registers with synchronous reset. Words already written
    // to program RAM are not affected by a reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            addr_q   <= 10'd0;
            instr_q  <= 18'd0;
            we_q     <= 1'b0;
            pbrst_q  <= 1'b0;
            err_q    <= 1'b0;
            remain_q <= 10'd0;
            b2_q     <= 2'd0;
            b1_q     <= 8'd0;
            tmo_q    <= '0;
`ifdef PB_LOADER_CHECKSUM_EN
            sum_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            we_q     <= we_d;
            pbrst_q  <= pbrst_d;
            err_q    <= err_d;
            remain_q <= remain_d;
            b2_q     <= b2_d;
            b1_q     <= b1_d;
            tmo_q    <= tmo_d;
`ifdef PB_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign in_ready_o         = ready_q;
    assign load_address_o     = addr_q;
    assign load_instruction_o = instr_q;
    assign load_we_o          = we_q;
    assign pb_reset_o         = pbrst_q;
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = (state_q == S_FIN);
    assign error_o            = err_q;

endmodule

// File: tb/tb_pb_code_loader.sv
// ---------------------------------------------------------------------------
// tb_pb_code_loader
//
// Self-checking bench for pb_code_loader. Frames are built from random or
// fixed words. The expected program-RAM contents are derived from the frame
// format: word k lands at address k with data {B2[1:0], B1, B0}. A monitor
// logs every write and watches the handshake: in_ready must be low exactly in
// WRITE and FIN cycles.
// ---------------------------------------------------------------------------
module tb_pb_code_loader;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  inData = 8'h00;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [9:0]  loadAddress;
    logic [17:0] loadInstruction;
    logic        loadWe;
    logic        pbReset;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  txQ[$];
    logic [17:0] expData[$];
    logic [28:0] obs[$];
    int          nWords = 0;

    logic [9:0]  monAddr[$];
    logic [17:0] monData[$];
    int          monReadyBad = 0;
    int          monBothBad = 0;
    logic        prevReset = 1'b1;

    pb_code_loader #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i             (clock),
        .reset_i           (reset),
        .in_data_i         (inData),
        .in_valid_i        (inValid),
        .in_ready_o        (inReady),
        .load_address_o    (loadAddress),
        .load_instruction_o(loadInstruction),
        .load_we_o         (loadWe),
        .pb_reset_o        (pbReset),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error)
    );

    always #5 clock = ~clock;

    // Write logger and handshake watcher, sampled away from the active edge
    always @(negedge clock) begin
        if (loadWe === 1'b1 && reset === 1'b0) begin
            monAddr.push_back(loadAddress);
            monData.push_back(loadInstruction);
        end
        if (reset === 1'b0 && prevReset === 1'b0 && inReady !== !(loadWe || done))
            monReadyBad++;
        if (done === 1'b1 && error === 1'b1)
            monBothBad++;
        prevReset = reset;
    end

    function automatic logic [7:0] nonSync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    task automatic newFrame(input int n, input bit junk);
        logic [9:0] m;
        logic [5:0] top;
        m   = 10'(n - 1);
        top = junk ? 6'($urandom) : 6'd0;
        txQ.delete();
        expData.delete();
        obs.delete();
        txQ.push_back(8'hA5);
        txQ.push_back({top, m[9:8]});
        txQ.push_back(m[7:0]);
        nWords = n;
    endtask

    task automatic addWord(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        txQ.push_back(b2);
        txQ.push_back(b1);
        txQ.push_back(b0);
        expData.push_back({b2[1:0], b1, b0});
    endtask

    task automatic addRandomWords(input int n);
        for (int k = 0; k < n; k++)
            addWord(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic closeFrame();
`ifdef PB_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 1; i < txQ.size(); i++) s = s + txQ[i];
        txQ.push_back(s);
`endif
    endtask

    // Drive one byte with a random idle gap; returns 1 time unit after the
    // edge on which the byte was accepted
    task automatic sendByte(input logic [7:0] b);
        int budget;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
        end
        inData  = b;
        inValid = 1'b1;
        budget  = 0;
        while (inReady !== 1'b1 && budget < 50) begin
            @(posedge clock); #1;
            budget++;
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sendByte: in_ready=%b after %0d cycles, required 1", inReady, budget);
        end
        @(posedge clock); #1;
        inValid = 1'b0;
        inData  = 8'($urandom);
    endtask

    // Send txQ[lo..hi-1]; the cycle after each B0 the write port is captured
    task automatic sendRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            sendByte(txQ[i]);
            if (i >= 3 && i < 3 + 3 * nWords && (i - 3) % 3 == 2)
                obs.push_back({loadWe, loadAddress, loadInstruction});
        end
    endtask

    task automatic observeEnd(output logic d, output logic e, output logic p);
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        d = done;
        e = error;
        p = pbReset;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        inValid = 1'b1;
        inData  = nonSync();
        repeat (2) begin
            @(posedge clock); #1;
        end
        checks++;
        if ({inReady, loadAddress, loadInstruction, loadWe, pbReset, busy, done, error} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got ready=%b addr=%h instr=%h we=%b pbrst=%b busy=%b done=%b err=%b, required all 0",
                     inReady, loadAddress, loadInstruction, loadWe, pbReset, busy, done, error);
        end
        reset   = 1'b0;
        inValid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({inReady, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_release: ready=%b busy=%b, required 1 0", inReady, busy);
        end
    endtask

    task automatic test_single();
        logic d, e, p;
        int   base;
        base = monData.size();
        newFrame(1, 1'b0);
        addWord(8'h00, 8'h12, 8'h34);
        closeFrame();
        sendRange(0, 1);
        checks++;
        if ({pbReset, busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL single_sync: pb_reset=%b busy=%b, required 1 1", pbReset, busy);
        end
        sendRange(1, txQ.size());
        checks++;
        if (obs.size() != 1 || obs[0] !== {1'b1, 10'd0, 18'h01234}) begin
            errors++;
            $display("[TB] FAIL single_write: got %h, required %h", obs.size() > 0 ? obs[0] : 29'h0, {1'b1, 10'd0, 18'h01234});
        end
        observeEnd(d, e, p);
        checks++;
        if ({d, e, p} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_done: done/err/pbrst=%b%b%b, required 101", d, e, p);
        end
        @(posedge clock); #1;
        checks++;
        if ({pbReset, done, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_release: pbrst/done/busy=%b%b%b, required 000", pbReset, done, busy);
        end
        checks++;
        if (monData.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL single_count: %0d writes, required 1", monData.size() - base);
        end
    endtask

    task automatic test_multi();
        logic d, e, p;
        int   base;
        base = monData.size();
        newFrame(3, 1'b0);
        addWord(8'h03, 8'hFF, 8'hFF);
        addWord(8'h00, 8'h00, 8'h01);
        addWord(8'h02, 8'hAB, 8'hCD);
        closeFrame();
        sendRange(0, txQ.size());
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= obs.size() || obs[k] !== {1'b1, 10'(k), expData[k]}) begin
                errors++;
                $display("[TB] FAIL multi_write%0d: got %h, required %h", k, k < obs.size() ? obs[k] : 29'h0, {1'b1, 10'(k), expData[k]});
            end
        end
        observeEnd(d, e, p);
        checks++;
        if ({d, e, p} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL multi_done: done/err/pbrst=%b%b%b, required 101", d, e, p);
        end
        checks++;
        if (monData.size() - base != 3) begin
            errors++;
            $display("[TB] FAIL multi_count: %0d writes, required 3", monData.size() - base);
        end
        checks++;
        if (monReadyBad !== 0) begin
            errors++;
            $display("[TB] FAIL multi_ready: %0d cycles with wrong in_ready, required 0", monReadyBad);
        end
    endtask

    task automatic test_garbage();
        logic [7:0] junk[3];
        logic d, e, p;
        int   base;
        junk[0] = 8'h00;
        junk[1] = 8'h11;
        junk[2] = 8'hFF;
        @(posedge clock); #1;
        base = monData.size();
        for (int i = 0; i < 3; i++) begin
            sendByte(junk[i]);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL garbage_busy%0d: busy=%b, required 0", i, busy);
            end
        end
        checks++;
        if (monData.size() != base) begin
            errors++;
            $display("[TB] FAIL garbage_nowrite: %0d writes, required 0", monData.size() - base);
        end
        newFrame(2, 1'b1);
        addRandomWords(2);
        closeFrame();
        sendRange(0, txQ.size());
        observeEnd(d, e, p);
        checks++;
        if ({d, e} !== 2'b10 || monData.size() - base != 2) begin
            errors++;
            $display("[TB] FAIL garbage_frame: done/err=%b%b writes=%0d, required 10 and 2", d, e, monData.size() - base);
        end
    endtask

    task automatic test_timeout();
        logic d, e, p;
        int   cyc;
        int   base;
        base = monData.size();
        newFrame(1, 1'b0);
        addWord(8'h00, 8'h00, 8'h00);
        closeFrame();
        sendRange(0, 4);
        cyc = 0;
        while (error !== 1'b1 && cyc < 3 * TMO) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (error !== 1'b1 || cyc < TMO - 1 || cyc > TMO + 1) begin
            errors++;
            $display("[TB] FAIL timeout_error: error=%b after %0d idle cycles, required 1 after about %0d", error, cyc, TMO);
        end
        checks++;
        if ({busy, pbReset, done} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL timeout_state: busy/pbrst/done=%b%b%b, required 010", busy, pbReset, done);
        end
        @(posedge clock); #1;
        checks++;
        if ({error, pbReset} !== 2'b01 || monData.size() != base) begin
            errors++;
            $display("[TB] FAIL timeout_after: err/pbrst=%b%b writes=%0d, required 01 and 0", error, pbReset, monData.size() - base);
        end
        newFrame(2, 1'b0);
        addRandomWords(2);
        closeFrame();
        sendRange(0, txQ.size());
        observeEnd(d, e, p);
        @(posedge clock); #1;
        checks++;
        if ({d, e, p, pbReset} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL timeout_recover: done/err/pbrst/pbrst_next=%b%b%b%b, required 1010", d, e, p, pbReset);
        end
    endtask

`ifdef PB_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        logic d, e, p;
        int   base;
        base = monData.size();
        newFrame(1, 1'b0);
        addWord(8'h00, 8'h12, 8'h34);
        closeFrame();
        txQ[txQ.size() - 1] = txQ[txQ.size() - 1] + 8'h01;
        sendRange(0, txQ.size());
        observeEnd(d, e, p);
        checks++;
        if ({d, e, p} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL badchk_error: done/err/pbrst=%b%b%b, required 011", d, e, p);
        end
        checks++;
        if (monData.size() - base != 1 || obs.size() != 1 || obs[0] !== {1'b1, 10'd0, 18'h01234}) begin
            errors++;
            $display("[TB] FAIL badchk_write: %0d writes, required 1 at addr 0 data 01234", monData.size() - base);
        end
        @(posedge clock); #1;
        checks++;
        if ({error, done, pbReset} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL badchk_after: err/done/pbrst=%b%b%b, required 001", error, done, pbReset);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic d, e, p;
        int   base;
        int   n;
        bit   bad;
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 2)) sendByte(nonSync());
            n    = $urandom_range(1, 6);
            base = monData.size();
            newFrame(n, 1'b1);
            addRandomWords(n);
            closeFrame();
            sendRange(0, txQ.size());
            bad = (obs.size() != n);
            for (int k = 0; k < n && !bad; k++)
                if (obs[k] !== {1'b1, 10'(k), expData[k]}) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL b2b_writes%0d: %0d write captures, required %0d matching the frame", f, obs.size(), n);
            end
            observeEnd(d, e, p);
            bad = (monData.size() - base != n);
            for (int k = 0; k < n && !bad; k++)
                if (monAddr[base + k] !== 10'(k) || monData[base + k] !== expData[k]) bad = 1'b1;
            checks++;
            if ({d, e, p} !== 3'b101 || bad) begin
                errors++;
                $display("[TB] FAIL b2b_frame%0d: done/err/pbrst=%b%b%b ram_ok=%b, required 101 and 1", f, d, e, p, !bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic d, e, p;
        int   base;
        bit   bad;
        base = monData.size();
        newFrame(8, 1'b1);
        addRandomWords(8);
        closeFrame();
        sendRange(0, 16);
        inValid = 1'b1;
        inData  = nonSync();
        reset   = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({inReady, loadAddress, loadInstruction, loadWe, pbReset, busy, done, error} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL midreset_values: ready=%b addr=%h instr=%h we=%b pbrst=%b busy=%b done=%b err=%b, required all 0",
                     inReady, loadAddress, loadInstruction, loadWe, pbReset, busy, done, error);
        end
        reset  = 1'b0;
        inData = nonSync();
        @(posedge clock); #1;
        checks++;
        if ({inReady, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midreset_idle: ready=%b busy=%b, required 1 0", inReady, busy);
        end
        inValid = 1'b0;
        bad = (monData.size() - base != 4);
        for (int k = 0; k < 4 && !bad; k++)
            if (monAddr[base + k] !== 10'(k) || monData[base + k] !== expData[k]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL midreset_partial: %0d writes before reset, required 4 matching the frame", monData.size() - base);
        end
        base = monData.size();
        newFrame(5, 1'b1);
        addRandomWords(5);
        closeFrame();
        sendRange(0, txQ.size());
        bad = (obs.size() != 5);
        for (int k = 0; k < 5 && !bad; k++)
            if (obs[k] !== {1'b1, 10'(k), expData[k]}) bad = 1'b1;
        observeEnd(d, e, p);
        checks++;
        if ({d, e} !== 2'b10 || bad || monData.size() - base != 5) begin
            errors++;
            $display("[TB] FAIL midreset_next: done/err=%b%b writes=%0d ok=%b, required 10, 5, 1", d, e, monData.size() - base, !bad);
        end
    endtask

    task automatic test_invariants();
        @(posedge clock); #1;
        checks++;
        if (monReadyBad !== 0 || monBothBad !== 0) begin
            errors++;
            $display("[TB] FAIL invariants: ready_violations=%0d done_and_error=%0d, required 0 0", monReadyBad, monBothBad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_garbage();
        test_timeout();
`ifdef PB_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
